// File: rtl/muestreo_multicanal_pkg.sv
// Shared definitions for the multi-channel sample-clock generator.
package muestreo_multicanal_pkg;

    // Divide limit loaded into every channel after reset.
    localparam int DEFAULT_LIM = 249999;

    // Per-channel output mode.
    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // Width of the channel-index field; never less than one bit.
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/muestreo_multicanal_canal.sv
// One sample-clock channel: free-running divider, active/pending limits and
// output shaping in toggle or pulse mode.
module canal_muestreo
    import muestreo_multicanal_pkg::*;
#(
    parameter int CNT_W   = 18,
    parameter int RST_LIM = DEFAULT_LIM
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_sync,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_clk,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_lim_act;
    logic [CNT_W-1:0] r_lim_pend;
    logic             r_pend_vld;
    mode_e            r_mode;
    logic             r_clk;
    logic             r_tick;

    logic             w_tc;
    mode_e            w_mode_in;

    assign w_tc      = (r_cnt == r_lim_act);
    assign w_mode_in = mode_e'(i_mode);

    // Counter, latched mode and output shaping.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; the reset branch is asynchronous.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_mode <= MODE_TOGGLE;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            r_mode <= w_mode_in;
        end else if (i_sync) begin
            // Phase align: sync wins over a coincident terminal count.
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (w_tc) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_mode <= w_mode_in;
            if (w_mode_in == MODE_PULSE) begin
                // Leaving toggle mode starts pulse mode from a clean low level.
                r_clk <= (r_mode == MODE_TOGGLE) ? 1'b0 : 1'b1;
            end else begin
                r_clk <= ~r_clk;
            end
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
            if (r_mode == MODE_PULSE) begin
                r_clk <= 1'b0;
            end
        end
    end

    // Pending/active limit handling; a new load is only ever staged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lim_act  <= CNT_W'(RST_LIM);
            r_lim_pend <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            if (r_pend_vld && (!i_en || i_sync || w_tc)) begin
                r_lim_act  <= r_lim_pend;
                r_pend_vld <= 1'b0;
            end
            // NOTE: this later assignment overrides the clear above, so a load
            // coincident with an application stays pending for the next one.
            if (i_load) begin
                r_lim_pend <= i_val;
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule

// File: rtl/muestreo_multicanal.sv
// Multi-channel sample-clock generator: limit-write decode, acknowledge and
// sync fan-out around N_CH independent channels.
module muestreo_multicanal #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 18,
    parameter int DEFAULT_LIM = muestreo_multicanal_pkg::DEFAULT_LIM
)(
    input  logic                                               Clck_in,
    input  logic                                               reset_Clock,
    input  logic [N_CH-1:0]                                    enable,
    input  logic [N_CH-1:0]                                    mode,
    input  logic                                               sync,
    input  logic                                               lim_load,
    input  logic [muestreo_multicanal_pkg::ch_idx_w(N_CH)-1:0] lim_ch,
    input  logic [CNT_W-1:0]                                   lim_val,
    output logic                                               lim_ack,
    output logic [N_CH-1:0]                                    Clock_out,
    output logic [N_CH-1:0]                                    tick
);

    localparam int CH_W = muestreo_multicanal_pkg::ch_idx_w(N_CH);

    logic            w_ch_ok;
    logic [N_CH-1:0] w_load;
    logic            r_ack;

    // Out-of-range channel indices only exist when N_CH is not a power of two.
    if (N_CH == (2 ** CH_W)) begin : g_ch_full
        assign w_ch_ok = 1'b1;
    end else begin : g_ch_part
        assign w_ch_ok = (lim_ch < CH_W'(N_CH));
    end

    // Acknowledge every accepted limit write one cycle later.
    always_ff @(posedge Clck_in or posedge reset_Clock) begin
        if (reset_Clock) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= lim_load && w_ch_ok;
        end
    end

    assign lim_ack = r_ack;

    for (genvar g = 0; g < N_CH; g++) begin : g_canal
        assign w_load[g] = lim_load && w_ch_ok && (lim_ch == CH_W'(g));

        canal_muestreo #(
            .CNT_W   (CNT_W),
            .RST_LIM (DEFAULT_LIM)
        ) u_canal (
            .i_clk  (Clck_in),
            .i_rst  (reset_Clock),
            .i_en   (enable[g]),
            .i_mode (mode[g]),
            .i_sync (sync),
            .i_load (w_load[g]),
            .i_val  (lim_val),
            .o_clk  (Clock_out[g]),
            .o_tick (tick[g])
        );
    end

endmodule

// File: tb/tb_muestreo_multicanal.sv
// Directed bench for muestreo_multicanal: a per-cycle vector table for the
// basic divide/toggle/pulse behaviour, then hand-written multi-cycle sequences.
module tb_muestreo_multicanal;

    localparam int N_CH    = 3;
    localparam int CNT_W   = 18;
    localparam int DEF_LIM = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_CH-1:0]  enable;
    logic [N_CH-1:0]  mode;
    logic             sync;
    logic             lim_load;
    logic [1:0]       lim_ch;
    logic [CNT_W-1:0] lim_val;
    logic             lim_ack;
    logic [N_CH-1:0]  clock_out;
    logic [N_CH-1:0]  tick;

    int n_pass  = 0;
    int n_total = 0;
    int ack_cnt = 0;
    int n, f0, f1, ack_snap;
    bit found;

    typedef struct {
        logic [2:0]  en;
        logic [2:0]  md;
        logic        ld;
        logic [17:0] val;
        logic [2:0]  e_tick;
        logic [2:0]  e_clk;
        logic        e_ack;
    } vec_t;

    vec_t vt[20];

    muestreo_multicanal #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_LIM (DEF_LIM)
    ) dut (
        .Clck_in     (clk),
        .reset_Clock (rst),
        .enable      (enable),
        .mode        (mode),
        .sync        (sync),
        .lim_load    (lim_load),
        .lim_ch      (lim_ch),
        .lim_val     (lim_val),
        .lim_ack     (lim_ack),
        .Clock_out   (clock_out),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lim_ack === 1'b1) ack_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Edges from the current negedge until tick[ch] is seen; -1 on timeout.
    task automatic wait_tick(input int ch, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (tick[ch] !== 1'b1 && cnt < 100);
        if (tick[ch] !== 1'b1) cnt = -1;
    endtask

    task automatic load(input logic [1:0] ch, input logic [17:0] val);
        lim_load = 1'b1;
        lim_ch   = ch;
        lim_val  = val;
        @(negedge clk);
        lim_load = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] en, input logic [2:0] md, input logic ld,
                                input logic [17:0] val, input logic [2:0] et,
                                input logic [2:0] ec, input logic ea);
        vec_t v;
        v.en = en; v.md = md; v.ld = ld; v.val = val;
        v.e_tick = et; v.e_clk = ec; v.e_ack = ea;
        return v;
    endfunction

    initial begin
        // Channel 0: limit 3 in toggle mode, then limit 0 in pulse mode.
        vt[0]  = mk(3'b000, 3'b000, 1'b1, 18'd3, 3'b000, 3'b000, 1'b1);
        vt[1]  = mk(3'b000, 3'b000, 1'b0, 18'd0, 3'b000, 3'b000, 1'b0);
        vt[2]  = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b000, 3'b000, 1'b0);
        vt[3]  = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b000, 3'b000, 1'b0);
        vt[4]  = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b000, 3'b000, 1'b0);
        vt[5]  = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b001, 3'b001, 1'b0);
        vt[6]  = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b000, 3'b001, 1'b0);
        vt[7]  = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b000, 3'b001, 1'b0);
        vt[8]  = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b000, 3'b001, 1'b0);
        vt[9]  = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b001, 3'b000, 1'b0);
        vt[10] = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b000, 3'b000, 1'b0);
        vt[11] = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b000, 3'b000, 1'b0);
        vt[12] = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b000, 3'b000, 1'b0);
        vt[13] = mk(3'b001, 3'b000, 1'b0, 18'd0, 3'b001, 3'b001, 1'b0);
        vt[14] = mk(3'b000, 3'b001, 1'b1, 18'd0, 3'b000, 3'b000, 1'b1);
        vt[15] = mk(3'b000, 3'b001, 1'b0, 18'd0, 3'b000, 3'b000, 1'b0);
        vt[16] = mk(3'b001, 3'b001, 1'b0, 18'd0, 3'b001, 3'b001, 1'b0);
        vt[17] = mk(3'b001, 3'b001, 1'b0, 18'd0, 3'b001, 3'b001, 1'b0);
        vt[18] = mk(3'b001, 3'b001, 1'b0, 18'd0, 3'b001, 3'b001, 1'b0);
        vt[19] = mk(3'b000, 3'b001, 1'b0, 18'd0, 3'b000, 3'b000, 1'b0);

        rst = 1'b1; enable = '0; mode = '0; sync = 1'b0;
        lim_load = 1'b0; lim_ch = '0; lim_val = '0;
        repeat (3) @(negedge clk);
        check("reset Clock_out", clock_out, 0);
        check("reset tick", tick, 0);
        check("reset lim_ack", lim_ack, 0);
        rst = 1'b0;

        // Table: drive at a negedge, compare after the following rising edge.
        for (int i = 0; i < 20; i++) begin
            enable   = vt[i].en;
            mode     = vt[i].md;
            lim_load = vt[i].ld;
            lim_ch   = 2'd0;
            lim_val  = vt[i].val;
            @(negedge clk);
            check($sformatf("row%0d tick", i), tick, vt[i].e_tick);
            check($sformatf("row%0d Clock_out", i), clock_out, vt[i].e_clk);
            check($sformatf("row%0d lim_ack", i), lim_ack, vt[i].e_ack);
        end
        lim_load = 1'b0;

        // Load coincident with terminal count: lim 9 -> 4.
        mode = '0;
        load(2'd0, 18'd9);
        @(negedge clk);
        enable = 3'b001;
        wait_tick(0, n);
        check("lim9 first tick", n, 10);
        repeat (9) @(negedge clk);
        ack_snap = ack_cnt;
        lim_load = 1'b1; lim_ch = 2'd0; lim_val = 18'd4;
        @(negedge clk);
        check("tc with load ticks", tick[0], 1);
        check("tc with load ack", lim_ack, 1);
        lim_load = 1'b0;
        wait_tick(0, n);
        check("interval after coincident load", n, 10);
        wait_tick(0, n);
        check("interval new lim a", n, 5);
        wait_tick(0, n);
        check("interval new lim b", n, 5);
        check("ack single cycle", ack_cnt - ack_snap, 1);

        // Sync aligns channels 0/1 (lim 5/7) running out of phase.
        enable = 3'b000;
        lim_load = 1'b1; lim_ch = 2'd0; lim_val = 18'd5;
        @(negedge clk);
        lim_ch = 2'd1; lim_val = 18'd7;
        @(negedge clk);
        lim_load = 1'b0;
        @(negedge clk);
        enable = 3'b001;
        repeat (3) @(negedge clk);
        enable = 3'b011;
        repeat (4) @(negedge clk);
        check("pre-sync Clock_out[0]", clock_out[0], 1);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        check("sync Clock_out", clock_out[1:0], 0);
        check("sync tick", tick[1:0], 0);
        f0 = -1; f1 = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (tick[0] === 1'b1 && f0 < 0) f0 = i;
            if (tick[1] === 1'b1 && f1 < 0) f1 = i;
        end
        check("sync ch0 first tick", f0, 6);
        check("sync ch1 first tick", f1, 8);

        // Out-of-range channel and last-write-wins on channel 0 (lim 5).
        enable = 3'b001;
        wait_tick(0, n);
        ack_snap = ack_cnt;
        load(2'd3, 18'd2);
        wait_tick(0, n);
        check("invalid ch keeps period", n, 5);
        check("invalid ch no ack", ack_cnt - ack_snap, 0);
        load(2'd0, 18'd5);
        load(2'd0, 18'd2);
        wait_tick(0, n);
        check("pending not yet applied", n, 4);
        wait_tick(0, n);
        check("last write wins", n, 3);
        check("two loads two acks", ack_cnt - ack_snap, 2);

        // Reset mid-period with a pending load.
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            wait_tick(0, n);
            if (clock_out[0] === 1'b1) found = 1'b1;
        end
        load(2'd0, 18'd1);
        check("pre-reset Clock_out[0]", clock_out[0], 1);
        #2 rst = 1'b1;
        #1;
        check("async reset Clock_out", clock_out, 0);
        check("async reset tick", tick, 0);
        check("async reset lim_ack", lim_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(0, n);
        check("post-reset first tick", n, DEF_LIM + 1);
        wait_tick(0, n);
        check("post-reset period", n, DEF_LIM + 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muestreo_multicanal.md
MUESTREO_MULTICANAL -- requirements
Module: muestreo_multicanal

Interface
REQ-001 Parameter N_CH, default 4: number of independent sample-clock channels, range 1..16.
REQ-002 Parameter CNT_W, default 18: counter and divide-limit width.
REQ-003 Parameter DEFAULT_LIM, default 249999: per-channel divide limit after reset.
REQ-004 Clck_in  in  1: single clock; all logic is on its rising edge.
REQ-005 reset_Clock  in  1: reset, asynchronous and active-high.
REQ-006 enable  in  N_CH: per-channel run enable.
REQ-007 mode  in  N_CH: per-channel output mode; 0 = toggle (square wave), 1 = pulse (one-cycle high).
REQ-008 sync  in  1: one-cycle phase-align strobe for all channels.
REQ-009 lim_load  in  1: one-cycle request to write a new divide limit.
REQ-010 lim_ch  in  clog2(N_CH) (min 1): target channel of lim_load.
REQ-011 lim_val  in  CNT_W: new divide limit for the target channel.
REQ-012 lim_ack  out  1: one-cycle acknowledge of an accepted lim_load.
REQ-013 Clock_out  out  N_CH: per-channel sample clock.
REQ-014 tick  out  N_CH: per-channel one-cycle strobe at each terminal count.

Function
REQ-015 Each channel SHALL hold a counter, an active limit and a pending limit with a pending-valid flag.
REQ-016 While enable[i]=1, counter SHALL increment by 1 each cycle until it equals the active limit (terminal count), then return to 0.
REQ-017 On terminal count, tick[i] SHALL be 1 in the next cycle only; Clock_out[i] SHALL invert in toggle mode and SHALL be 1 for that one cycle in pulse mode.
REQ-018 Period SHALL be lim+1 cycles between ticks; the toggle-mode Clock_out period SHALL be 2*(lim+1) cycles; lim=0 SHALL give a tick every cycle.
REQ-019 While enable[i]=0, counter, Clock_out[i] and tick[i] SHALL be 0 on the next edge; on re-enable, the first tick SHALL occur lim+1 cycles after the first enabled cycle.
REQ-020 An accepted lim_load SHALL write lim_val into the pending limit, set pending-valid and assert lim_ack in the following cycle.
REQ-021 lim_load with lim_ch >= N_CH SHALL be ignored, with no lim_ack.
REQ-022 A pending limit SHALL become active at the channel's next terminal count, at sync, or immediately when the channel is disabled; pending-valid then clears.
REQ-023 A load coincident with a terminal count SHALL NOT affect that count; the new value SHALL apply at the following terminal count.
REQ-024 A second load before application SHALL overwrite the pending value (last write wins).
REQ-025 A mode change SHALL take effect only at terminal count or while disabled; a toggle-to-pulse change SHALL force Clock_out to 0 at that point.
REQ-026 sync=1 SHALL zero the counters, Clock_out and tick of all enabled channels on the next edge and apply pending limits; sync takes priority over a coincident terminal count.
REQ-027 Channels SHALL be fully independent except for the shared sync and limit-write port.

Reset
REQ-028 Reset SHALL clear all counters and pending-valid flags, and set Clock_out=0, tick=0, lim_ack=0 and the active limits to DEFAULT_LIM.
REQ-029 Reset mid-period SHALL discard pending limits and the latched mode; the first post-reset tick SHALL follow DEFAULT_LIM+1 enabled cycles.

Structure
REQ-030 A shared package SHALL hold DEFAULT_LIM, the mode encodings (MODE_TOGGLE=0, MODE_PULSE=1) and the channel-index width function.
REQ-031 One sub-module, canal_muestreo (single channel: counter, limits, output logic), SHALL be instantiated N_CH times by a generate loop; the top level holds only load decode, lim_ack and sync fan-out.

Verification
REQ-032 Reset, enable[0]=1, toggle, lim=3 -> tick[0] every 4 cycles, Clock_out[0] period 8 cycles, 50% duty.
REQ-033 Pulse mode, lim=0 -> tick and Clock_out high every cycle; disable -> both 0 on the next edge.
REQ-034 lim=9 running, load lim_val=4 on the same cycle as a terminal count -> the next interval is 10 cycles, then 5-cycle intervals; lim_ack is high for 1 cycle.
REQ-035 Channels 0/1 with lim=5/7 out of phase, pulse sync -> both counters are 0 on the next edge, first ticks 6 and 8 cycles later.
REQ-036 lim_load with lim_ch=N_CH -> no lim_ack and no limit change; two loads 5 then 2 before terminal count -> 2 applies.
REQ-037 Assert reset_Clock mid-period with a pending load -> outputs 0 asynchronously; after release, period = DEFAULT_LIM+1.
